// File: rtl/rv32im_alu_pkg.sv
// rv32im_alu_pkg
//   Shared constants for the RV32IM execute-stage ALU. The decode stage
//   imports the same operation codes, so any change here changes the
//   encoding on both sides of the ID/EX boundary.
//   Contents: WIDTH / SEL_W sizing constants and the ALU_* operation codes.
package rv32im_alu_pkg;

  localparam int WIDTH = 32;
  localparam int SEL_W = 5;

  localparam logic [SEL_W-1:0] ALU_ADD    = 5'd0;
  localparam logic [SEL_W-1:0] ALU_SUB    = 5'd1;
  localparam logic [SEL_W-1:0] ALU_SLL    = 5'd2;
  localparam logic [SEL_W-1:0] ALU_SLT    = 5'd3;
  localparam logic [SEL_W-1:0] ALU_SLTU   = 5'd4;
  localparam logic [SEL_W-1:0] ALU_XOR    = 5'd5;
  localparam logic [SEL_W-1:0] ALU_SRL    = 5'd6;
  localparam logic [SEL_W-1:0] ALU_SRA    = 5'd7;
  localparam logic [SEL_W-1:0] ALU_OR     = 5'd8;
  localparam logic [SEL_W-1:0] ALU_AND    = 5'd9;
  localparam logic [SEL_W-1:0] ALU_MUL    = 5'd10;
  localparam logic [SEL_W-1:0] ALU_MULH   = 5'd11;
  localparam logic [SEL_W-1:0] ALU_MULHSU = 5'd12;
  localparam logic [SEL_W-1:0] ALU_MULHU  = 5'd13;
  localparam logic [SEL_W-1:0] ALU_DIV    = 5'd14;
  localparam logic [SEL_W-1:0] ALU_DIVU   = 5'd15;
  localparam logic [SEL_W-1:0] ALU_REM    = 5'd16;
  localparam logic [SEL_W-1:0] ALU_REMU   = 5'd17;
  localparam logic [SEL_W-1:0] ALU_FWD    = 5'd18;

endpackage

// File: rtl/rv32im_alu_if.sv
// rv32im_alu_if
//   Operand/result bundle between the ID/EX register and the ALU.
//   data1  : operand A (rs1 or PC)
//   data2  : operand B (rs2 or immediate)
//   select : operation code (ALU_* in rv32im_alu_pkg)
//   result : registered ALU result, valid one cycle after the operands
//   master : drives operands, observes result (pipeline / testbench side)
//   slave  : consumes operands, drives result (ALU side)
interface rv32im_alu_if;
  import rv32im_alu_pkg::*;

  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [SEL_W-1:0] select;
  logic [WIDTH-1:0] result;

  modport master (output data1, output data2, output select, input result);
  modport slave  (input data1, input data2, input select, output result);

endinterface

// File: rtl/rv32im_alu_muldiv.sv
// alu_muldiv
//   Purely combinational M-extension unit: MUL, MULH, MULHSU, MULHU,
//   DIV, DIVU, REM, REMU including divide-by-zero and signed overflow.
//   a, b : operands
//   sel  : operation code; non-M codes give 0
//   y    : result
module alu_muldiv
  import rv32im_alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] y
);

  // One 64x64 multiplier serves all four multiply ops: each operand is
  // sign- or zero-extended to 64 bits, and the low 64 bits of the product
  // are then the correct two's-complement product for that signedness.
  logic             a_mul_signed;
  logic             b_mul_signed;
  logic [63:0]      a_ext;
  logic [63:0]      b_ext;
  logic [63:0]      prod;

  assign a_mul_signed = (sel == ALU_MULH) || (sel == ALU_MULHSU);
  assign b_mul_signed = (sel == ALU_MULH);
  assign a_ext = {{WIDTH{a_mul_signed & a[WIDTH-1]}}, a};
  assign b_ext = {{WIDTH{b_mul_signed & b[WIDTH-1]}}, b};
  assign prod  = a_ext * b_ext;

  // Signed divide/remainder run on magnitudes through the same unsigned
  // divider, then the signs are restored. The overflow case
  // (0x80000000 / -1) falls out naturally: |A| = 0x80000000, |B| = 1,
  // signs match, so the quotient stays 0x80000000 and the remainder 0.
  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic             b_zero;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quot_mag;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  assign div_signed = (sel == ALU_DIV) || (sel == ALU_REM);
  assign a_neg      = div_signed & a[WIDTH-1];
  assign b_neg      = div_signed & b[WIDTH-1];
  assign b_zero     = (b == '0);
  assign a_mag      = a_neg ? (~a + 32'd1) : a;
  assign b_mag      = b_neg ? (~b + 32'd1) : b;
  // Keeps the divider away from a zero divisor; that result is overridden.
  assign divisor    = b_zero ? 32'd1 : b_mag;
  assign quot_mag   = a_mag / divisor;
  assign rem_mag    = a_mag % divisor;
  assign quot       = (a_neg ^ b_neg) ? (~quot_mag + 32'd1) : quot_mag;
  assign rem        = a_neg ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    y = '0;
    case (sel)
      ALU_MUL:                       y = prod[WIDTH-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: y = prod[2*WIDTH-1:WIDTH];
      ALU_DIV, ALU_DIVU:             y = b_zero ? '1 : quot;
      ALU_REM, ALU_REMU:             y = b_zero ? a : rem;
      default:                       y = '0;
    endcase
  end

endmodule

// File: rtl/rv32im_alu.sv
// rv32im_alu
//   RV32IM execute-stage integer ALU with a one-cycle registered result.
//   CLK   : rising-edge clock
//   RESET : asynchronous active-high reset, clears the result
//   alu   : slave side of rv32im_alu_if (data1, data2, select -> result)
//   Base RV32I ops are decoded here; M-extension ops come from alu_muldiv.
module rv32im_alu
  import rv32im_alu_pkg::*;
(
  input  logic            CLK,
  input  logic            RESET,
  rv32im_alu_if.slave     alu
);

  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] muldiv_y;
  logic [4:0]       shamt;

  alu_muldiv u_muldiv (
    .a   (alu.data1),
    .b   (alu.data2),
    .sel (alu.select),
    .y   (muldiv_y)
  );

  // Shift amount uses only the low five bits of operand B.
  assign shamt = alu.data2[4:0];

  always_comb begin
    result_d = '0;
    case (alu.select)
      ALU_ADD:  result_d = alu.data1 + alu.data2;
      ALU_SUB:  result_d = alu.data1 - alu.data2;
      ALU_SLL:  result_d = alu.data1 << shamt;
      ALU_SLT:  result_d = {{(WIDTH-1){1'b0}}, ($signed(alu.data1) < $signed(alu.data2))};
      ALU_SLTU: result_d = {{(WIDTH-1){1'b0}}, (alu.data1 < alu.data2)};
      ALU_XOR:  result_d = alu.data1 ^ alu.data2;
      ALU_SRL:  result_d = alu.data1 >> shamt;
      ALU_SRA:  result_d = $signed(alu.data1) >>> shamt;
      ALU_OR:   result_d = alu.data1 | alu.data2;
      ALU_AND:  result_d = alu.data1 & alu.data2;
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:
                result_d = muldiv_y;
      ALU_FWD:  result_d = alu.data2;
      default:  result_d = '0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) result_q <= '0;
    else       result_q <= result_d;
  end

  assign alu.result = result_q;

endmodule

// File: tb/tb_rv32im_alu.sv
// tb_rv32im_alu
//   Self-checking bench for rv32im_alu: directed scenarios for reset,
//   division/multiply corners, shifts, compares and back-to-back issue,
//   followed by randomized operations compared against a reference model.
module tb_rv32im_alu;

  logic CLK;
  logic RESET;
  int   checks;
  int   failures;

  rv32im_alu_if bus ();

  rv32im_alu dut (
    .CLK   (CLK),
    .RESET (RESET),
    .alu   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: computes each operation from its arithmetic meaning
  // using 64-bit integers and the language's own signed division.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input int sel);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    longint          p;
    longint unsigned up;
    int              ia;
    int              ib;
    int              sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = int'(a);
    ib = int'(b);
    sh = int'(b & 32'h1F);
    case (sel)
      0:  return a + b;
      1:  return a - b;
      2:  begin up = ua * (64'd1 << sh); return up[31:0]; end
      3:  return (sa < sb) ? 32'd1 : 32'd0;
      4:  return (ua < ub) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  begin up = ua / (64'd1 << sh); return up[31:0]; end
      7:  begin p = sa >>> sh; return p[31:0]; end
      8:  return a | b;
      9:  return a & b;
      10: begin p = sa * sb; return p[31:0]; end
      11: begin p = sa * sb; return p[63:32]; end
      12: begin p = sa * longint'(ub); return p[63:32]; end
      13: begin up = ua * ub; return up[63:32]; end
      14: begin
            if (b == 32'd0) return 32'hFFFFFFFF;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
            return 32'(ia / ib);
          end
      15: begin
            if (b == 32'd0) return 32'hFFFFFFFF;
            up = ua / ub;
            return up[31:0];
          end
      16: begin
            if (b == 32'd0) return a;
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'd0;
            return 32'(ia % ib);
          end
      17: begin
            if (b == 32'd0) return a;
            up = ua % ub;
            return up[31:0];
          end
      18: return b;
      default: return 32'd0;
    endcase
  endfunction

  // Drives one operation on the falling edge and returns #1 after the
  // following rising edge, where the registered result is sampled.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input int sel);
    @(negedge CLK);
    bus.data1  = a;
    bus.data2  = b;
    bus.select = 5'(sel);
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset;
    RESET      = 1'b1;
    bus.data1  = 32'd7;
    bus.data2  = 32'd9;
    bus.select = 5'd0;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (bus.result !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_hold got=%h exp=%h", bus.result, 32'd0);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_add_and_async_reset;
    issue(32'd1, 32'd2, 0);
    checks++;
    if (bus.result !== 32'd3) begin
      failures++;
      $display("[TB] FAIL add_1_2 got=%h exp=%h", bus.result, 32'd3);
    end
    issue(32'd5, 32'd2, 0);
    checks++;
    if (bus.result !== 32'd7) begin
      failures++;
      $display("[TB] FAIL add_5_2 got=%h exp=%h", bus.result, 32'd7);
    end
    // Mid-cycle assertion must clear the result without a clock edge.
    #2;
    RESET = 1'b1;
    #1;
    checks++;
    if (bus.result !== 32'd0) begin
      failures++;
      $display("[TB] FAIL async_reset got=%h exp=%h", bus.result, 32'd0);
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_div_corners;
    logic [31:0] a_tab [5] = '{32'd4, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
    logic [31:0] b_tab [5] = '{32'hFFFFFFFE, 32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
    int          s_tab [5] = '{14, 14, 16, 14, 16};
    logic [31:0] e_tab [5] = '{32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'd0};
    for (int i = 0; i < 5; i++) begin
      issue(a_tab[i], b_tab[i], s_tab[i]);
      checks++;
      if (bus.result !== e_tab[i]) begin
        failures++;
        $display("[TB] FAIL div_corner[%0d] sel=%0d got=%h exp=%h", i, s_tab[i], bus.result, e_tab[i]);
      end
    end
  endtask

  task automatic test_div_by_zero;
    logic [31:0] e_tab [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd123, 32'd123};
    for (int i = 0; i < 4; i++) begin
      issue(32'd123, 32'd0, 14 + i);
      checks++;
      if (bus.result !== e_tab[i]) begin
        failures++;
        $display("[TB] FAIL div_by_zero sel=%0d got=%h exp=%h", 14 + i, bus.result, e_tab[i]);
      end
    end
  endtask

  task automatic test_multiply;
    logic [31:0] e_tab [4] = '{32'd1, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFE};
    for (int i = 0; i < 4; i++) begin
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 10 + i);
      checks++;
      if (bus.result !== e_tab[i]) begin
        failures++;
        $display("[TB] FAIL mul_neg1 sel=%0d got=%h exp=%h", 10 + i, bus.result, e_tab[i]);
      end
    end
  endtask

  task automatic test_shift_compare;
    logic [31:0] a_tab [5] = '{32'h80000000, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b_tab [5] = '{32'h21, 32'h21, 32'h21, 32'd1, 32'd1};
    int          s_tab [5] = '{6, 7, 2, 3, 4};
    logic [31:0] e_tab [5] = '{32'h40000000, 32'hC0000000, 32'd0, 32'd1, 32'd0};
    for (int i = 0; i < 5; i++) begin
      issue(a_tab[i], b_tab[i], s_tab[i]);
      checks++;
      if (bus.result !== e_tab[i]) begin
        failures++;
        $display("[TB] FAIL shift_cmp[%0d] sel=%0d got=%h exp=%h", i, s_tab[i], bus.result, e_tab[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a_tab [4] = '{32'd3, 32'hF0, 32'd0, 32'hDEAD};
    logic [31:0] b_tab [4] = '{32'd5, 32'hFF, 32'h12345000, 32'hBEEF};
    int          s_tab [4] = '{1, 5, 18, 25};
    logic [31:0] e_tab [4] = '{32'hFFFFFFFE, 32'h0F, 32'h12345000, 32'd0};
    logic [31:0] prev;
    issue(32'd0, 32'hA5A5A5A5, 18);
    prev = 32'hA5A5A5A5;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      bus.data1  = a_tab[i];
      bus.data2  = b_tab[i];
      bus.select = 5'(s_tab[i]);
      #1;
      checks++;
      if (bus.result !== prev) begin
        failures++;
        $display("[TB] FAIL b2b_hold[%0d] got=%h exp=%h", i, bus.result, prev);
      end
      @(posedge CLK);
      #1;
      checks++;
      if (bus.result !== e_tab[i]) begin
        failures++;
        $display("[TB] FAIL b2b_result[%0d] sel=%0d got=%h exp=%h", i, s_tab[i], bus.result, e_tab[i]);
      end
      prev = e_tab[i];
    end
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          sel;
    for (int i = 0; i < 400; i++) begin
      a   = pick_operand();
      b   = pick_operand();
      sel = (i < 32) ? i : int'($urandom_range(0, 31));
      exp = ref_alu(a, b, sel);
      issue(a, b, sel);
      checks++;
      if (bus.result !== exp) begin
        failures++;
        $display("[TB] FAIL random sel=%0d a=%h b=%h got=%h exp=%h", sel, a, b, bus.result, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add_and_async_reset();
    test_div_corners();
    test_div_by_zero();
    test_multiply();
    test_shift_compare();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
